// File: rtl/fpga_ring_ctrl_pkg.sv
// Shared definitions for the LED ring sequencer: opcodes, FSM states and
// the power-on tick period.
package fpga_ring_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_SET_DIV = 3'd1;
    localparam logic [2:0] OP_LOAD    = 3'd2;
    localparam logic [2:0] OP_RUN_L   = 3'd3;
    localparam logic [2:0] OP_RUN_R   = 3'd4;
    localparam logic [2:0] OP_BOUNCE  = 3'd5;
    localparam logic [2:0] OP_STOP    = 3'd6;
    localparam logic [2:0] OP_STEP    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN_L = 3'd1,
        ST_RUN_R = 3'd2,
        ST_BNC_L = 3'd3,
        ST_BNC_R = 3'd4
    } state_t;

    localparam int DEFAULT_DIV = 10_000_000;

endpackage

// File: rtl/fpga_ring_ctrl_if.sv
// Host command channel: one opcode plus operand, valid/ready handshake.
interface fpga_ring_ctrl_if #(
    parameter int DIV_W = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [DIV_W-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/fpga_ring_prescaler.sv
// Reload-on-zero down-counter. 'tick' flags the cycle the count sits at
// zero; the owner registers it and uses it to gate ring updates.
module fpga_ring_prescaler
    import fpga_ring_pkg::*;
#(
    parameter int               DIV_W     = 24,
    parameter logic [DIV_W-1:0] RESET_VAL = DIV_W'(DEFAULT_DIV - 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    logic [DIV_W-1:0] r_cntr;

    assign tick = (r_cntr == '0);

    // Count down, reload from the period on expiry, or restart on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntr <= RESET_VAL;
        end else if (load) begin
            r_cntr <= load_val;
        end else if (tick) begin
            r_cntr <= reload_val;
        end else begin
            r_cntr <= r_cntr - 1'b1;
        end
    end

endmodule

// File: rtl/fpga_ring_ctrl.sv
// Command-driven LED ring sequencer: accepts one host command every other
// cycle, owns the tick period and the ring pattern, and rotates the ring
// left, right or back and forth on each prescaler tick.
module fpga_ring_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    fpga_ring_ctrl_if.slave     cmd,
    output logic [WIDTH-1:0]    o_ring_out,
    output logic                o_tick_out,
    output logic [2:0]          o_mode
);

    import fpga_ring_pkg::*;

    state_t           r_state;
    logic [WIDTH-1:0] r_ring;
    logic [DIV_W-1:0] r_div;
    logic             r_ready;
    logic             r_tick;

    logic             w_accept;
    logic             w_tick;
    logic             w_preLoad;
    logic [DIV_W-1:0] w_preVal;
    logic [WIDTH-1:0] w_rotl;
    logic [WIDTH-1:0] w_rotr;

    assign w_accept  = cmd.cmd_valid & r_ready;
    assign w_preLoad = w_accept & ((cmd.cmd_op == OP_SET_DIV) | (cmd.cmd_op == OP_LOAD));
    assign w_preVal  = (cmd.cmd_op == OP_SET_DIV) ? cmd.cmd_data : r_div;
    assign w_rotl    = {r_ring[WIDTH-2:0], r_ring[WIDTH-1]};
    assign w_rotr    = {r_ring[0], r_ring[WIDTH-1:1]};

    fpga_ring_prescaler #(
        .DIV_W     (DIV_W),
        .RESET_VAL (DIV_W'(DEFAULT_DIV - 1))
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_preLoad),
        .load_val   (w_preVal),
        .reload_val (r_div),
        .tick       (w_tick)
    );

    // Sequencer: an accepted command always takes priority over a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ring  <= WIDTH'(1);
            r_div   <= DIV_W'(DEFAULT_DIV - 1);
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= w_tick;
            r_ready <= ~w_accept;
            if (w_accept) begin
                case (cmd.cmd_op)
                    OP_SET_DIV: r_div   <= cmd.cmd_data;
                    OP_LOAD:    r_ring  <= cmd.cmd_data[WIDTH-1:0];
                    OP_RUN_L:   r_state <= ST_RUN_L;
                    OP_RUN_R:   r_state <= ST_RUN_R;
                    OP_BOUNCE:  r_state <= ST_BNC_L;
                    OP_STOP:    r_state <= ST_IDLE;
                    OP_STEP: begin
                        if (r_state == ST_IDLE) begin
                            r_ring <= w_rotl;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (w_tick) begin
                case (r_state)
                    ST_RUN_L: r_ring <= w_rotl;
                    ST_RUN_R: r_ring <= w_rotr;
                    ST_BNC_L: begin
                        if (r_ring[WIDTH-1]) begin
                            r_state <= ST_BNC_R;
                            r_ring  <= w_rotr;
                        end else begin
                            r_ring  <= w_rotl;
                        end
                    end
                    ST_BNC_R: begin
                        if (r_ring[0]) begin
                            r_state <= ST_BNC_L;
                            r_ring  <= w_rotl;
                        end else begin
                            r_ring  <= w_rotr;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign cmd.cmd_ready = r_ready;
    assign o_ring_out    = r_ring;
    assign o_tick_out    = r_tick;
    assign o_mode        = r_state;

endmodule
